tlb_op_ctrl: RTL and testbench

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

---
 rtl/tlb_op_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// TLB instruction controller: sequences TLBP/TLBR/TLBWI/TLBWR through a
// one-cycle search/read/write stage and a one-cycle completion stage, and
// maintains the Random register used to pick the TLBWR victim entry.
module tlb_op_ctrl #(
   parameter  int TLBNUM = 16,
   localparam int IW     = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          rst,
   // pipeline request
   input  logic          op_valid,
   input  logic [1:0]    op_type,
   output logic          op_ready,
   output logic          busy,
   output logic          done,
   // CP0 state
   input  logic [18:0]   hi_vpn2,
   input  logic [7:0]    hi_asid,
   input  logic [19:0]   lo0_pfn,
   input  logic [2:0]    lo0_c,
   input  logic          lo0_d,
   input  logic          lo0_v,
   input  logic          lo0_g,
   input  logic [19:0]   lo1_pfn,
   input  logic [2:0]    lo1_c,
   input  logic          lo1_d,
   input  logic          lo1_v,
   input  logic          lo1_g,
   input  logic [IW-1:0] index_in,
   input  logic [IW-1:0] wired,
   input  logic          wired_we,
   // TLB search port
   output logic [18:0]   s_vpn2,
   output logic          s_odd_page,
   output logic [7:0]    s_asid,
   input  logic          s_found,
   input  logic [IW-1:0] s_index,
   // TLB write port
   output logic          tlb_we,
   output logic [IW-1:0] w_index,
   output logic [18:0]   w_vpn2,
   output logic [7:0]    w_asid,
   output logic          w_g,
   output logic [19:0]   w_pfn0,
   output logic [2:0]    w_c0,
   output logic          w_d0,
   output logic          w_v0,
   output logic [19:0]   w_pfn1,
   output logic [2:0]    w_c1,
   output logic          w_d1,
   output logic          w_v1,
   // TLB read port
   output logic [IW-1:0] r_index,
   input  logic [18:0]   r_vpn2,
   input  logic [7:0]    r_asid,
   input  logic          r_g,
   input  logic [19:0]   r_pfn0,
   input  logic [2:0]    r_c0,
   input  logic          r_d0,
   input  logic          r_v0,
   input  logic [19:0]   r_pfn1,
   input  logic [2:0]    r_c1,
   input  logic          r_d1,
   input  logic          r_v1,
   // CP0 results
   output logic          idx_we,
   output logic          idx_p,
   output logic [IW-1:0] idx_val,
   output logic          entry_we,
   output logic [18:0]   e_vpn2,
   output logic [7:0]    e_asid,
   output logic [19:0]   e_pfn0,
   output logic [2:0]    e_c0,
   output logic          e_d0,
   output logic          e_v0,
   output logic          e_g0,
   output logic [19:0]   e_pfn1,
   output logic [2:0]    e_c1,
   output logic          e_d1,
   output logic          e_v1,
   output logic          e_g1,
   output logic [IW-1:0] random
);

   typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_READ, S_WRITE, S_DONE} state_t;

   localparam logic [1:0]    OP_TLBP  = 2'b00;
   localparam logic [1:0]    OP_TLBR  = 2'b01;
   localparam logic [1:0]    OP_TLBWR = 2'b11;
   localparam logic [IW-1:0] RND_TOP  = IW'(TLBNUM - 1);

   state_t        state, nxt;
   logic          accept;
   logic [1:0]    op_q;
   logic [IW-1:0] idx_q, rnd_q;
   logic [18:0]   vpn2_q;
   logic [7:0]    asid_q;
   logic [19:0]   pfn0_q, pfn1_q;
   logic [2:0]    c0_q, c1_q;
   logic          d0_q, v0_q, g0_q, d1_q, v1_q, g1_q;
   logic          found_q;
   logic [IW-1:0] sidx_q;
   logic [18:0]   rd_vpn2;
   logic [7:0]    rd_asid;
   logic          rd_g;
   logic [19:0]   rd_pfn0, rd_pfn1;
   logic [2:0]    rd_c0, rd_c1;
   logic          rd_d0, rd_v0, rd_d1, rd_v1;

   assign accept = op_valid && op_ready;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   // next state and per-state strobes; every strobe is zero outside its state
   always_comb begin
      nxt      = state;
      op_ready = 1'b0;
      tlb_we   = 1'b0;
      idx_we   = 1'b0;
      entry_we = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) begin
               case (op_type)
                  OP_TLBP: nxt = S_SEARCH;
                  OP_TLBR: nxt = S_READ;
                  default: nxt = S_WRITE;
               endcase
            end
         end
         S_SEARCH: nxt = S_DONE;
         S_READ:   nxt = S_DONE;
         S_WRITE: begin
            tlb_we = 1'b1;
            nxt    = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            idx_we   = (op_q == OP_TLBP);
            entry_we = (op_q == OP_TLBR);
            nxt      = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // snapshot of the request and CP0 state, so CP0 may change while busy
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= '0; idx_q <= '0; rnd_q <= '0; vpn2_q <= '0; asid_q <= '0;
         pfn0_q <= '0; c0_q <= '0; d0_q <= 1'b0; v0_q <= 1'b0; g0_q <= 1'b0;
         pfn1_q <= '0; c1_q <= '0; d1_q <= 1'b0; v1_q <= 1'b0; g1_q <= 1'b0;
      end else if (accept) begin
         op_q <= op_type; idx_q <= index_in; rnd_q <= random;
         vpn2_q <= hi_vpn2; asid_q <= hi_asid;
         pfn0_q <= lo0_pfn; c0_q <= lo0_c; d0_q <= lo0_d; v0_q <= lo0_v; g0_q <= lo0_g;
         pfn1_q <= lo1_pfn; c1_q <= lo1_c; d1_q <= lo1_d; v1_q <= lo1_v; g1_q <= lo1_g;
      end
   end

   // capture TLB search result and read data at the end of their stages
   always_ff @(posedge clk) begin
      if (rst) begin
         found_q <= 1'b0; sidx_q <= '0;
         rd_vpn2 <= '0; rd_asid <= '0; rd_g <= 1'b0;
         rd_pfn0 <= '0; rd_c0 <= '0; rd_d0 <= 1'b0; rd_v0 <= 1'b0;
         rd_pfn1 <= '0; rd_c1 <= '0; rd_d1 <= 1'b0; rd_v1 <= 1'b0;
      end else if (state == S_SEARCH) begin
         found_q <= s_found; sidx_q <= s_index;
      end else if (state == S_READ) begin
         rd_vpn2 <= r_vpn2; rd_asid <= r_asid; rd_g <= r_g;
         rd_pfn0 <= r_pfn0; rd_c0 <= r_c0; rd_d0 <= r_d0; rd_v0 <= r_v0;
         rd_pfn1 <= r_pfn1; rd_c1 <= r_c1; rd_d1 <= r_d1; rd_v1 <= r_v1;
      end
   end

   // Random counts down from the top and wraps back when it reaches Wired;
   // a Wired write restarts it, taking priority over the decrement
   always_ff @(posedge clk) begin
      if (rst || wired_we || random == wired) random <= RND_TOP;
      else                                    random <= random - 1'b1;
   end

   assign busy       = ~op_ready;
   assign s_vpn2     = vpn2_q;
   assign s_asid     = asid_q;
   assign s_odd_page = 1'b0;
   assign r_index    = idx_q;

   assign w_index = (op_q == OP_TLBWR) ? rnd_q : idx_q;
   assign w_vpn2  = vpn2_q;
   assign w_asid  = asid_q;
   assign w_g     = g0_q & g1_q;
   assign w_pfn0  = pfn0_q;
   assign w_c0    = c0_q;
   assign w_d0    = d0_q;
   assign w_v0    = v0_q;
   assign w_pfn1  = pfn1_q;
   assign w_c1    = c1_q;
   assign w_d1    = d1_q;
   assign w_v1    = v1_q;

   assign idx_p   = ~found_q;
   assign idx_val = found_q ? sidx_q : '0;

   assign e_vpn2 = rd_vpn2;
   assign e_asid = rd_asid;
   assign e_pfn0 = rd_pfn0;
   assign e_c0   = rd_c0;
   assign e_d0   = rd_d0;
   assign e_v0   = rd_v0;
   assign e_g0   = rd_g;
   assign e_pfn1 = rd_pfn1;
   assign e_c1   = rd_c1;
   assign e_d1   = rd_d1;
   assign e_v1   = rd_v1;
   assign e_g1   = rd_g;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small behavioural TLB attached to
// the search/read/write ports.
module tb_tlb_op_ctrl;

   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          op_valid, op_ready, busy, done;
   logic [1:0]    op_type;
   logic [18:0]   hi_vpn2;
   logic [7:0]    hi_asid;
   logic [19:0]   lo0_pfn, lo1_pfn;
   logic [2:0]    lo0_c, lo1_c;
   logic          lo0_d, lo0_v, lo0_g, lo1_d, lo1_v, lo1_g;
   logic [IW-1:0] index_in, wired;
   logic          wired_we;
   logic [18:0]   s_vpn2;
   logic          s_odd_page;
   logic [7:0]    s_asid;
   logic          s_found;
   logic [IW-1:0] s_index;
   logic          tlb_we;
   logic [IW-1:0] w_index;
   logic [18:0]   w_vpn2;
   logic [7:0]    w_asid;
   logic          w_g;
   logic [19:0]   w_pfn0, w_pfn1;
   logic [2:0]    w_c0, w_c1;
   logic          w_d0, w_v0, w_d1, w_v1;
   logic [IW-1:0] r_index;
   logic [18:0]   r_vpn2;
   logic [7:0]    r_asid;
   logic          r_g;
   logic [19:0]   r_pfn0, r_pfn1;
   logic [2:0]    r_c0, r_c1;
   logic          r_d0, r_v0, r_d1, r_v1;
   logic          idx_we, idx_p, entry_we;
   logic [IW-1:0] idx_val, random;
   logic [18:0]   e_vpn2;
   logic [7:0]    e_asid;
   logic [19:0]   e_pfn0, e_pfn1;
   logic [2:0]    e_c0, e_c1;
   logic          e_d0, e_v0, e_g0, e_d1, e_v1, e_g1;

   tlb_op_ctrl #(.TLBNUM(16)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
      .op_ready(op_ready), .busy(busy), .done(done),
      .hi_vpn2(hi_vpn2), .hi_asid(hi_asid),
      .lo0_pfn(lo0_pfn), .lo0_c(lo0_c), .lo0_d(lo0_d), .lo0_v(lo0_v), .lo0_g(lo0_g),
      .lo1_pfn(lo1_pfn), .lo1_c(lo1_c), .lo1_d(lo1_d), .lo1_v(lo1_v), .lo1_g(lo1_g),
      .index_in(index_in), .wired(wired), .wired_we(wired_we),
      .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
      .s_found(s_found), .s_index(s_index),
      .tlb_we(tlb_we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
      .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
      .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
      .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
      .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
      .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
      .idx_we(idx_we), .idx_p(idx_p), .idx_val(idx_val), .entry_we(entry_we),
      .e_vpn2(e_vpn2), .e_asid(e_asid),
      .e_pfn0(e_pfn0), .e_c0(e_c0), .e_d0(e_d0), .e_v0(e_v0), .e_g0(e_g0),
      .e_pfn1(e_pfn1), .e_c1(e_c1), .e_d1(e_d1), .e_v1(e_v1), .e_g1(e_g1),
      .random(random)
   );

   always #5 clk = ~clk;

   // behavioural TLB
   typedef struct packed {
      logic        vld;
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0, v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1, v1;
   } tlbe_t;

   tlbe_t mem [16];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (tlb_we) begin
         mem[w_index] <= '{vld: 1'b1, vpn2: w_vpn2, asid: w_asid, g: w_g,
                           pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                           pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
      end
   end

   always_comb begin
      s_found = 1'b0;
      s_index = '0;
      for (int i = 0; i < 16; i++)
         if (mem[i].vld && mem[i].vpn2 == s_vpn2 && (mem[i].g || mem[i].asid == s_asid)) begin
            s_found = 1'b1;
            s_index = 4'(i);
         end
   end

   assign r_vpn2 = mem[r_index].vpn2;
   assign r_asid = mem[r_index].asid;
   assign r_g    = mem[r_index].g;
   assign r_pfn0 = mem[r_index].pfn0;
   assign r_c0   = mem[r_index].c0;
   assign r_d0   = mem[r_index].d0;
   assign r_v0   = mem[r_index].v0;
   assign r_pfn1 = mem[r_index].pfn1;
   assign r_c1   = mem[r_index].c1;
   assign r_d1   = mem[r_index].d1;
   assign r_v1   = mem[r_index].v1;

   // strobe counters, sampled before each edge updates the DUT
   int n_we = 0, n_done = 0, n_idx = 0, n_ent = 0;
   always @(posedge clk) begin
      n_we   <= n_we + int'(tlb_we);
      n_done <= n_done + int'(done);
      n_idx  <= n_idx + int'(idx_we);
      n_ent  <= n_ent + int'(entry_we);
   end

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // one-cycle request; returns on the falling edge of the stage cycle
   task automatic issue(input logic [1:0] t);
      op_valid = 1'b1;
      op_type  = t;
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   int rnd_seq [14] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 15, 14};
   int snap;
   bit hit;

   initial begin
      rst = 1'b1; op_valid = 1'b0; op_type = 2'b00;
      hi_vpn2 = '0; hi_asid = '0;
      lo0_pfn = '0; lo0_c = '0; lo0_d = 0; lo0_v = 0; lo0_g = 0;
      lo1_pfn = '0; lo1_c = '0; lo1_d = 0; lo1_v = 0; lo1_g = 0;
      index_in = '0; wired = '0; wired_we = 1'b0;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_ready", op_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tlb_we", tlb_we, 0);
      chk("rst_idx_we", idx_we, 0);
      chk("rst_entry_we", entry_we, 0);
      chk("rst_random", random, 15);
      chk("rst_w_vpn2", w_vpn2, 0);
      chk("rst_e_vpn2", e_vpn2, 0);
      chk("rst_idx_val", idx_val, 0);

      // Random sequence with wired=4
      wired = 4;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 14; k++) begin
         chk($sformatf("rnd_seq%0d", k), random, rnd_seq[k]);
         @(negedge clk);
      end

      // TLBWI: install vpn2 0x12345 / asid 3 at entry 5
      hi_vpn2 = 19'h12345; hi_asid = 8'd3; index_in = 4'd5;
      lo0_pfn = 20'h00500; lo0_v = 1; lo1_pfn = 20'h00501; lo1_v = 1;
      issue(2'b10);
      chk("wi5_we", tlb_we, 1);
      chk("wi5_idx", w_index, 5);
      @(negedge clk);
      chk("wi5_done", done, 1);
      @(negedge clk);

      // TLBP hit
      issue(2'b00);
      chk("ph_busy", busy, 1);
      chk("ph_done_early", done, 0);
      chk("ph_s_vpn2", s_vpn2, 19'h12345);
      chk("ph_s_asid", s_asid, 3);
      chk("ph_odd", s_odd_page, 0);
      @(negedge clk);
      chk("ph_done", done, 1);
      chk("ph_idx_we", idx_we, 1);
      chk("ph_idx_p", idx_p, 0);
      chk("ph_idx_val", idx_val, 5);
      chk("ph_entry_we", entry_we, 0);
      @(negedge clk);
      chk("ph_ready", op_ready, 1);
      chk("ph_done_off", done, 0);

      // TLBP miss
      snap = n_we;
      hi_vpn2 = 19'h07777; hi_asid = 8'd1;
      issue(2'b00);
      @(negedge clk);
      chk("pm_idx_we", idx_we, 1);
      chk("pm_idx_p", idx_p, 1);
      chk("pm_idx_val", idx_val, 0);
      @(negedge clk);
      chk("pm_no_we", n_we - snap, 0);

      // TLBWI entry 9, mixed global bits
      snap = n_we;
      hi_vpn2 = 19'h0ABCD; hi_asid = 8'h22; index_in = 4'd9;
      lo0_pfn = 20'h11111; lo0_c = 3; lo0_d = 1; lo0_v = 1; lo0_g = 1;
      lo1_pfn = 20'h22222; lo1_c = 2; lo1_d = 0; lo1_v = 1; lo1_g = 0;
      issue(2'b10);
      chk("wi9_we", tlb_we, 1);
      chk("wi9_idx", w_index, 9);
      chk("wi9_g", w_g, 0);
      chk("wi9_vpn2", w_vpn2, 19'h0ABCD);
      chk("wi9_pfn1", w_pfn1, 20'h22222);
      hi_vpn2 = '0; lo0_pfn = '0; lo1_pfn = '0; index_in = 4'd2;
      @(negedge clk);
      chk("wi9_we_off", tlb_we, 0);
      chk("wi9_done", done, 1);
      @(negedge clk);
      chk("wi9_one_we", n_we - snap, 1);

      // TLBR entry 9
      index_in = 4'd9;
      issue(2'b01);
      chk("r9_index", r_index, 9);
      chk("r9_no_we", tlb_we, 0);
      @(negedge clk);
      chk("r9_entry_we", entry_we, 1);
      chk("r9_idx_we", idx_we, 0);
      chk("r9_vpn2", e_vpn2, 19'h0ABCD);
      chk("r9_asid", e_asid, 8'h22);
      chk("r9_pfn0", e_pfn0, 20'h11111);
      chk("r9_c0", e_c0, 3);
      chk("r9_d0", e_d0, 1);
      chk("r9_pfn1", e_pfn1, 20'h22222);
      chk("r9_c1", e_c1, 2);
      chk("r9_d1", e_d1, 0);
      chk("r9_g0", e_g0, 0);
      chk("r9_g1", e_g1, 0);
      @(negedge clk);

      // TLBWR accepted while random == 7
      hit = 0;
      for (int k = 0; k < 40 && !hit; k++) begin
         if (random == 7) hit = 1;
         else @(negedge clk);
      end
      chk("wr_wait7", random, 7);
      index_in = 4'd1;
      issue(2'b11);
      chk("wr_we", tlb_we, 1);
      chk("wr_idx", w_index, 7);
      @(negedge clk);
      @(negedge clk);

      // wired_we restart from a mid value
      hit = 0;
      for (int k = 0; k < 40 && !hit; k++) begin
         if (random == 10) hit = 1;
         else @(negedge clk);
      end
      chk("ww_wait10", random, 10);
      wired_we = 1'b1;
      @(negedge clk);
      wired_we = 1'b0;
      chk("ww_top", random, 15);
      @(negedge clk);
      chk("ww_dec", random, 14);

      // wired = TLBNUM-1 pins random at the top
      wired = 4'd15; wired_we = 1'b1;
      @(negedge clk);
      wired_we = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("wtop%0d", k), random, 15);
         @(negedge clk);
      end
      wired = 4'd4;

      // op_valid held through a busy op: no re-accept until back in IDLE
      snap = n_done;
      hi_vpn2 = 19'h12345; hi_asid = 8'd3;
      op_valid = 1'b1; op_type = 2'b00;
      @(negedge clk);
      chk("hold_busy1", op_ready, 0);
      @(negedge clk);
      chk("hold_busy2", op_ready, 0);
      chk("hold_done", done, 1);
      @(negedge clk);
      chk("hold_idle", op_ready, 1);
      @(negedge clk);
      chk("hold_reacc", busy, 1);
      op_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("hold_two_done", n_done - snap, 2);

      // reset during WRITE
      index_in = 4'd3;
      issue(2'b10);
      chk("rm_we", tlb_we, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rm_ready", op_ready, 1);
      chk("rm_busy", busy, 0);
      snap = n_we + n_done + n_idx + n_ent;
      repeat (4) @(negedge clk);
      chk("rm_no_pulses", n_we + n_done + n_idx + n_ent - snap, 0);
      chk("rm_random", random, 11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1);
   end

endmodule
